// File: rtl/matrix_add_stream_loader.sv
// Stream loader for the parallel-vector matrix adder: collects row-major A/B element pairs
// into a ping-pong operand buffer and presents a complete frame per bank swap.
//
// state    | meaning
// ST_FILL  | writing pairs into the non-presented bank, checking in_last framing
// ST_DRAIN | frame overran without in_last; discarding pairs until in_last is seen
module matrix_add_stream_loader #(
  parameter int IN_WIDTH = 16,
  parameter int ROWS     = 11,
  parameter int COLS     = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_WIDTH-1:0]           in_a,
  input  logic [IN_WIDTH-1:0]           in_b,
  input  logic                          in_last,
  output logic [ROWS*COLS*IN_WIDTH-1:0] a_flat,
  output logic [ROWS*COLS*IN_WIDTH-1:0] b_flat,
  output logic                          out_ready,
  output logic                          bank_sel,
  output logic                          frame_err,
  output logic [15:0]                   frame_cnt
);

  localparam int NELEM = ROWS * COLS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IDX_W = (NELEM > 1) ? $clog2(NELEM) : 1;

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NELEM - 1);

  typedef enum logic {
    ST_FILL,
    ST_DRAIN
  } state_e;

  state_e                          state_q, state_d;
  logic [ROW_W-1:0]                row_q, row_d;
  logic [COL_W-1:0]                col_q, col_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            bank_sel_q, bank_sel_d;
  logic [15:0]                     frame_cnt_q, frame_cnt_d;
  logic                            rdy_pend_q, rdy_pend_d;
  logic                            err_pend_q, err_pend_d;
  logic                            wr_en;
  logic                            accept;
  logic                            last_slot;

  logic [1:0][NELEM-1:0][IN_WIDTH-1:0] bank_a_q;
  logic [1:0][NELEM-1:0][IN_WIDTH-1:0] bank_b_q;

  assign in_ready  = enable & reset;
  assign accept    = enable & in_valid & in_ready;
  assign last_slot = (idx_q == IDX_MAX);

  // Pulses are held pending while enable is low and released on the first enabled cycle.
  assign out_ready = rdy_pend_q & enable;
  assign frame_err = err_pend_q & enable;
  assign bank_sel  = bank_sel_q;
  assign frame_cnt = frame_cnt_q;
  assign a_flat    = bank_a_q[bank_sel_q];
  assign b_flat    = bank_b_q[bank_sel_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FILL;
      row_q       <= '0;
      col_q       <= '0;
      idx_q       <= '0;
      bank_sel_q  <= 1'b0;
      frame_cnt_q <= '0;
      rdy_pend_q  <= 1'b0;
      err_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      idx_q       <= idx_d;
      bank_sel_q  <= bank_sel_d;
      frame_cnt_q <= frame_cnt_d;
      rdy_pend_q  <= rdy_pend_d;
      err_pend_q  <= err_pend_d;
    end
  end

  // Only the fill bank (~bank_sel_q) is ever written, so presented data stays stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_a_q <= '0;
      bank_b_q <= '0;
    end else if (wr_en) begin
      bank_a_q[~bank_sel_q][idx_q] <= in_a;
      bank_b_q[~bank_sel_q][idx_q] <= in_b;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    idx_d       = idx_q;
    bank_sel_d  = bank_sel_q;
    frame_cnt_d = frame_cnt_q;
    rdy_pend_d  = rdy_pend_q & ~enable;
    err_pend_d  = err_pend_q & ~enable;
    wr_en       = 1'b0;

    if (accept) begin
      unique case (state_q)
        ST_FILL: begin
          if (in_last || last_slot) begin
            row_d = '0;
            col_d = '0;
            idx_d = '0;
            if (in_last && last_slot) begin
              wr_en       = 1'b1;
              bank_sel_d  = ~bank_sel_q;
              frame_cnt_d = frame_cnt_q + 16'd1;
              rdy_pend_d  = 1'b1;
            end else begin
              err_pend_d = 1'b1;
              if (!in_last) begin
                state_d = ST_DRAIN;
              end
            end
          end else begin
            wr_en = 1'b1;
            idx_d = idx_q + 1'b1;
            if (col_q == COL_MAX) begin
              col_d = '0;
              row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (in_last) begin
            state_d = ST_FILL;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

endmodule
